router_write_arbiter: RTL and testbench

- Shares the single write port of the arbiter data FIFO between NUM_REQ receive-side requesters, such as per-link receive controllers.
- Each requester raises arbiter_write_req. The block grants one requester at a time in round-robin order.
- The grant is held for one full burst of NUMBER_PACKET accepted beats.
- Beats are forwarded to the FIFO under valid/ready backpressure from full_arbiter_fifo.

---
 rtl/router_pkg.sv | 18 +
 rtl/rr_pick.sv | 30 +++
 rtl/router_write_arbiter.sv | 161 ++++++++++++++++
 tb/tb_router_write_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router types and parameter defaults (write arbiter, read-side scheduler).
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package router_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_XFER    = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    localparam int ROUTER_DATA_WIDTH     = 1024;
    localparam int ROUTER_ADDR_WIDTH     = 10;
    localparam int ROUTER_DATA_DFX_WIDTH = ROUTER_DATA_WIDTH + ROUTER_ADDR_WIDTH;
    localparam int ROUTER_NUMBER_PACKET  = 19;
    localparam int ROUTER_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after i_ptr, wrapping modulo N.
// Latency: combinational.
// Backpressure: none; o_vld low when no request is set.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic             o_vld
);

    always_comb begin
        o_gnt = '0;
        o_vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(i_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!o_vld && i_req[idx]) begin
                o_gnt[idx] = 1'b1;
                o_vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_write_arbiter.sv
// Round-robin share of the arbiter FIFO write port; grant held for NUMBER_PACKET beats.
// Latency: request-to-grant 1 cycle; beats pass combinationally; one RELEASE dead cycle per burst.
// Backpressure: full_arbiter_fifo drops wr_ready of the owner. ARB_TIMEOUT_EN aborts stalled bursts.
module router_write_arbiter
    import router_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = ROUTER_DATA_WIDTH,
    parameter int ADDR_WIDTH     = ROUTER_ADDR_WIDTH,
    parameter int DATA_DFX_WIDTH = DATA_WIDTH + ADDR_WIDTH,
    parameter int NUMBER_PACKET  = ROUTER_NUMBER_PACKET,
    parameter int TIMEOUT_CYCLES = ROUTER_TIMEOUT_CYCLES
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  arbiter_write_req,
    output logic [NUM_REQ-1:0]                  arbiter_write_gnt,
    input  logic [NUM_REQ-1:0]                  wr_valid,
    input  logic [NUM_REQ*DATA_DFX_WIDTH-1:0]   wr_data,
    output logic [NUM_REQ-1:0]                  wr_ready,
    input  logic                                full_arbiter_fifo,
    output logic                                write_arbiter_fifo,
    output logic [DATA_DFX_WIDTH-1:0]           data_arbiter_fifo,
    output logic                                arb_busy,
    output logic                                arb_timeout_err
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(NUMBER_PACKET + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || NUMBER_PACKET < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("router_write_arbiter: illegal parameter combination");
    end

    arb_state_t         r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [PTR_W-1:0]   r_sel;
    logic [PTR_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;

    logic [NUM_REQ-1:0] w_pick_gnt;
    logic               w_pick_vld;
    logic [PTR_W-1:0]   w_pick_idx;
    logic               w_xfer;
    logic               w_accept;
    logic               w_last;
    logic [PTR_W-1:0]   w_next_ptr;

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .i_req (arbiter_write_req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_vld (w_pick_vld)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_gnt[i]) begin
                w_pick_idx = PTR_W'(i);
            end
        end
    end

    assign w_xfer     = (r_state == ARB_XFER);
    assign w_accept   = w_xfer & wr_valid[r_sel] & ~full_arbiter_fifo;
    assign w_last     = (r_cnt == CNT_W'(NUMBER_PACKET - 1));
    assign w_next_ptr = (r_sel == PTR_W'(NUM_REQ - 1)) ? '0 : r_sel + 1'b1;

    // Only the owner sees ready; everyone else is isolated from the FIFO.
    always_comb begin
        wr_ready          = '0;
        data_arbiter_fifo = '0;
        if (w_xfer) begin
            wr_ready[r_sel]   = ~full_arbiter_fifo;
            data_arbiter_fifo = wr_data[int'(r_sel)*DATA_DFX_WIDTH +: DATA_DFX_WIDTH];
        end
    end

    assign write_arbiter_fifo = w_accept;
    assign arbiter_write_gnt  = r_gnt;
    assign arb_busy           = r_busy;

`ifdef ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] r_stall;
    logic               r_timeout_err;
    assign arb_timeout_err = r_timeout_err;
`else
    assign arb_timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_stall       <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_vld) begin
                        r_state <= ARB_XFER;
                        r_gnt   <= w_pick_gnt;
                        r_sel   <= w_pick_idx;
                        r_busy  <= 1'b1;
                    end
                end
                ARB_XFER: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_state <= ARB_RELEASE;
                            r_gnt   <= '0;
                            r_busy  <= 1'b0;
                            r_cnt   <= '0;
                            r_ptr   <= w_next_ptr;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    // Stall window restarts on every accepted beat.
                    if (w_accept) begin
                        r_stall <= '0;
                    end else if (r_stall == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state       <= ARB_RELEASE;
                        r_gnt         <= '0;
                        r_busy        <= 1'b0;
                        r_cnt         <= '0;
                        r_ptr         <= w_next_ptr;
                        r_stall       <= '0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_stall <= r_stall + 1'b1;
                    end
`endif
                end
                ARB_RELEASE: begin
                    r_state <= ARB_IDLE;
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_write_arbiter.sv
// Directed bench for router_write_arbiter: reset, single burst, round robin, backpressure,
// request drop/isolation, mid-burst reset, and the stall timeout when ARB_TIMEOUT_EN is defined.
module tb_router_write_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int DDW = DW + AW;
    localparam int NP  = 19;
    localparam int TO  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     valid = '0;
    logic [NR*DDW-1:0] wdata = '0;
    logic [NR-1:0]     rdy;
    logic              full = 1'b0;
    logic              wr;
    logic [DDW-1:0]    dat;
    logic              busy;
    logic              err;

    always #5 clk = ~clk;

    router_write_arbiter #(
        .NUM_REQ        (NR),
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .DATA_DFX_WIDTH (DDW),
        .NUMBER_PACKET  (NP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .arbiter_write_req  (req),
        .arbiter_write_gnt  (gnt),
        .wr_valid           (valid),
        .wr_data            (wdata),
        .wr_ready           (rdy),
        .full_arbiter_fifo  (full),
        .write_arbiter_fifo (wr),
        .data_arbiter_fifo  (dat),
        .arb_busy           (busy),
        .arb_timeout_err    (err)
    );

    int checks = 0;
    int errors = 0;
    int src_cnt[NR];
    int exp_beat[NR];

    logic          s_wr, s_busy, s_err;
    logic [NR-1:0] s_gnt, s_rdy;
    logic [DDW-1:0] s_dat;

    // Each source presents {tag=index, beat number}; the beat advances when it is accepted.
    task automatic drive_data();
        for (int i = 0; i < NR; i++) begin
            wdata[i*DDW +: DDW] = {8'(i), 16'(src_cnt[i])};
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        valid = '0;
        full  = 1'b0;
        for (int i = 0; i < NR; i++) begin
            src_cnt[i]  = 0;
            exp_beat[i] = 0;
        end
        drive_data();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Sample mid-cycle, then advance sources past the following rising edge.
    task automatic step();
        @(negedge clk);
        s_wr   = wr;
        s_dat  = dat;
        s_gnt  = gnt;
        s_rdy  = rdy;
        s_busy = busy;
        s_err  = err;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (s_rdy[i] && valid[i]) src_cnt[i]++;
        end
        drive_data();
    endtask

    function automatic int gidx(input logic [NR-1:0] g);
        int r;
        r = -1;
        for (int i = 0; i < NR; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic test_reset();
        req   = '1;
        valid = '1;
        #12;
        checks++;
        if ({gnt, rdy, wr, dat, busy, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b rdy=%b wr=%b dat=%h busy=%b err=%b, required all 0",
                     gnt, rdy, wr, dat, busy, err);
        end
    endtask

    task automatic test_single();
        do_reset();
        req   = 4'b0100;
        valid = 4'b0100;
        step();
        checks++;
        if (s_gnt !== 4'b0000 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: gnt=%b busy=%b, required 0000/0", s_gnt, s_busy);
        end
        step();
        checks++;
        if (s_gnt !== 4'b0100 || s_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: gnt=%b busy=%b, required 0100/1", s_gnt, s_busy);
        end
        for (int b = 0; b < NP; b++) begin
            checks++;
            if (s_wr !== 1'b1 || s_rdy !== 4'b0100 || s_dat !== {8'd2, 16'(b)}) begin
                errors++;
                $display("FAIL single_beat%0d: wr=%b rdy=%b dat=%h, required 1/0100/%h",
                         b, s_wr, s_rdy, s_dat, {8'd2, 16'(b)});
            end
            step();
        end
        checks++;
        if (s_gnt !== 4'b0000 || s_busy !== 1'b0 || s_wr !== 1'b0) begin
            errors++;
            $display("FAIL single_release: gnt=%b busy=%b wr=%b, required 0000/0/0", s_gnt, s_busy, s_wr);
        end
        // Pointer must now be 3: with requests 0 and 2, requester 0 wins.
        req = 4'b0101;
        step();
        step();
        checks++;
        if (s_gnt !== 4'b0001) begin
            errors++;
            $display("FAIL single_ptr_next: gnt=%b, required 0001", s_gnt);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req   = '1;
        valid = '1;
        step();
        for (int g = 0; g < 5; g++) begin
            int gap;
            int nw;
            int k;
            logic [NR-1:0] eg;
            gap = 0;
            nw  = 0;
            eg  = NR'(1) << (g % NR);
            while (s_gnt === '0 && gap < 8) begin
                gap++;
                step();
            end
            checks++;
            if (gap != ((g == 0) ? 1 : 2)) begin
                errors++;
                $display("FAIL rr_gap%0d: dead cycles=%0d, required %0d", g, gap, (g == 0) ? 1 : 2);
            end
            checks++;
            if (s_gnt !== eg) begin
                errors++;
                $display("FAIL rr_order%0d: gnt=%b, required %b", g, s_gnt, eg);
            end
            k = g % NR;
            for (int c = 0; c < 60 && s_gnt === eg; c++) begin
                if (s_wr) begin
                    checks++;
                    if (s_dat !== {8'(k), 16'(exp_beat[k])}) begin
                        errors++;
                        $display("FAIL rr_data%0d: dat=%h, required %h", g, s_dat, {8'(k), 16'(exp_beat[k])});
                    end
                    exp_beat[k]++;
                    nw++;
                end
                step();
            end
            checks++;
            if (nw != NP) begin
                errors++;
                $display("FAIL rr_count%0d: writes=%0d, required %0d", g, nw, NP);
            end
        end
    endtask

    task automatic test_backpressure();
        int nw;
        int stalls;
        do_reset();
        req   = 4'b1000;
        valid = 4'b1000;
        nw     = 0;
        stalls = 0;
        step();
        for (int c = 0; c < 40 && nw < NP; c++) begin
            full = (nw == 4 && stalls < 3);
            step();
            if (full) begin
                stalls++;
                checks++;
                if (s_wr !== 1'b0 || s_rdy !== 4'b0000 || s_gnt !== 4'b1000) begin
                    errors++;
                    $display("FAIL bp_stall: wr=%b rdy=%b gnt=%b, required 0/0000/1000", s_wr, s_rdy, s_gnt);
                end
            end else if (s_wr) begin
                checks++;
                if (s_dat !== {8'd3, 16'(nw)} || s_rdy !== 4'b1000) begin
                    errors++;
                    $display("FAIL bp_beat%0d: dat=%h rdy=%b, required %h/1000", nw, s_dat, s_rdy, {8'd3, 16'(nw)});
                end
                nw++;
            end
        end
        full = 1'b0;
        step();
        checks++;
        if (nw != NP || stalls != 3 || s_gnt !== 4'b0000 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_total: writes=%0d stalls=%0d gnt=%b busy=%b, required %0d/3/0000/0",
                     nw, stalls, s_gnt, s_busy, NP);
        end
    endtask

    task automatic test_req_drop();
        int nw;
        do_reset();
        req   = 4'b0010;
        valid = 4'b0011;
        nw    = 0;
        step();
        step();
        checks++;
        if (s_gnt !== 4'b0010) begin
            errors++;
            $display("FAIL drop_grant: gnt=%b, required 0010", s_gnt);
        end
        for (int c = 0; c < 60 && s_gnt === 4'b0010; c++) begin
            checks++;
            if (s_rdy[0] !== 1'b0 || (s_wr && s_dat !== {8'd1, 16'(nw)})) begin
                errors++;
                $display("FAIL drop_isolate: rdy=%b dat=%h, required rdy[0]=0 dat=%h", s_rdy, s_dat, {8'd1, 16'(nw)});
            end
            if (s_wr) nw++;
            if (nw == 3) req = '0;
            step();
        end
        checks++;
        if (nw != NP) begin
            errors++;
            $display("FAIL drop_count: writes=%0d, required %0d", nw, NP);
        end
        step();
        step();
        checks++;
        if (s_gnt !== 4'b0000 || s_wr !== 1'b0) begin
            errors++;
            $display("FAIL drop_no_regrant: gnt=%b wr=%b, required 0000/0", s_gnt, s_wr);
        end
    endtask

    task automatic test_reset_mid_burst();
        int nw;
        do_reset();
        req   = 4'b0100;
        valid = 4'b0100;
        nw    = 0;
        step();
        for (int c = 0; c < 40 && nw < 10; c++) begin
            step();
            if (s_wr) nw++;
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, rdy, wr, dat, busy, err} !== '0) begin
            errors++;
            $display("FAIL midrst_async: gnt=%b rdy=%b wr=%b dat=%h busy=%b, required all 0", gnt, rdy, wr, dat, busy);
        end
        do_reset();
        req   = 4'b0101;
        valid = 4'b0101;
        step();
        step();
        checks++;
        if (s_gnt !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_regrant: gnt=%b, required 0001", s_gnt);
        end
        nw = 0;
        for (int c = 0; c < 40 && s_gnt === 4'b0001; c++) begin
            if (s_wr) nw++;
            step();
        end
        checks++;
        if (nw != NP) begin
            errors++;
            $display("FAIL midrst_count: writes=%0d, required %0d", nw, NP);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req   = 4'b0011;
        valid = 4'b0000;
        step();
        step();
        for (int c = 0; c < TO; c++) begin
            checks++;
            if (s_gnt !== 4'b0001 || s_err !== 1'b0) begin
                errors++;
                $display("FAIL to_hold%0d: gnt=%b err=%b, required 0001/0", c, s_gnt, s_err);
            end
            step();
        end
        checks++;
        if (s_gnt !== 4'b0000 || s_err !== 1'b1 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse: gnt=%b err=%b busy=%b, required 0000/1/0", s_gnt, s_err, s_busy);
        end
        step();
        checks++;
        if (s_err !== 1'b0) begin
            errors++;
            $display("FAIL to_single: err=%b, required 0", s_err);
        end
        step();
        checks++;
        if (s_gnt !== 4'b0010) begin
            errors++;
            $display("FAIL to_next: gnt=%b, required 0010", s_gnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_req_drop();
        test_reset_mid_burst();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
